conv_frame_ctrl: RTL

Frame sequencer for the rate-1/2 convolutional encoder (3-stage shift register; c0 = FF3^FF1, c1 = FF3^FF2^FF1).
- Accepts a frame length, buffers that many information bits through a valid/ready handshake, then feeds them to the encoder at one bit per clock.
- Appends zero tail bits to flush the encoder.
- Registers each (c0, c1) pair with framing flags.
- Clears the encoder between frames through the encoder's active-high reset.

---
 rtl/conv_frame_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for a rate-1/2, 3-stage convolutional encoder.
// Collects a frame of information bits, streams them into the external
// encoder followed by zero tail bits, and registers each (c0, c1) pair
// with first/last framing flags. The encoder is held in reset between frames.
module conv_frame_ctrl #(
  parameter int MAX_LEN  = 64,
  parameter int LEN_W    = 7,
  parameter int TAIL_LEN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] frm_len,
  output logic             busy,
  output logic             len_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  output logic             enc_rst,
  output logic             enc_b0,
  input  logic             enc_c0,
  input  logic             enc_c1,
  output logic             out_valid,
  output logic             out_c0,
  output logic             out_c1,
  output logic             out_first,
  output logic             out_last,
  output logic             done
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ENC   = 3'd2,
    TAIL  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] cnt_inc;
  logic             len_err_q, len_err_d;
  logic             enc_rst_q, enc_rst_d;
  logic             len_ok;
  logic             ready_c;
  logic             wr_en;
  logic             act_c;
  logic             first_c;
  logic             last_c;

  // Output pipeline: stage p1 lines up with the encoder's response,
  // the output registers follow one cycle later.
  logic             vld_p1_q, first_p1_q, last_p1_q;
  logic             out_valid_q, out_c0_q, out_c1_q;
  logic             out_first_q, out_last_q, done_q;

  logic             buf_q [MAX_LEN];

  assign len_ok  = (frm_len != '0) && (frm_len <= LEN_W'(MAX_LEN));
  assign ready_c = (state_q == LOAD) && (cnt_q < len_q);
  assign cnt_inc = cnt_q + LEN_W'(1);

  // Next-state logic: frame sequencing and the shared bit/cycle counter
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            len_d   = frm_len;
            cnt_d   = '0;
            state_d = LOAD;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (in_valid && ready_c) begin
          wr_en = 1'b1;
          if (cnt_inc == len_q) begin
            cnt_d   = '0;
            state_d = ENC;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ENC: begin
        if (cnt_q == len_q - LEN_W'(1)) begin
          cnt_d   = '0;
          state_d = TAIL;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      TAIL: begin
        if (cnt_q == LEN_W'(TAIL_LEN - 1)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      DRAIN: begin
        // Two cycles let the last tail pair reach the output registers
        if (cnt_q == LEN_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    // Derived from the next state so the encoder reset is a clean flop output
    enc_rst_d = (state_d == IDLE) || (state_d == LOAD);
  end

  assign act_c   = (state_q == ENC) || (state_q == TAIL);
  assign first_c = (state_q == ENC) && (cnt_q == '0);
  assign last_c  = (state_q == TAIL) && (cnt_q == LEN_W'(TAIL_LEN - 1));

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      len_err_q   <= 1'b0;
      enc_rst_q   <= 1'b1;
      vld_p1_q    <= 1'b0;
      first_p1_q  <= 1'b0;
      last_p1_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_c0_q    <= 1'b0;
      out_c1_q    <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      len_err_q   <= len_err_d;
      enc_rst_q   <= enc_rst_d;
      // p1: bit driven last cycle is now visible on enc_c0/enc_c1
      vld_p1_q    <= act_c;
      first_p1_q  <= first_c;
      last_p1_q   <= last_c;
      // p2: capture the encoder pair; forced to zero when not valid
      out_valid_q <= vld_p1_q;
      out_c0_q    <= vld_p1_q & enc_c0;
      out_c1_q    <= vld_p1_q & enc_c1;
      out_first_q <= first_p1_q;
      out_last_q  <= last_p1_q;
      done_q      <= last_p1_q;
    end
  end

  // Frame buffer: pure data storage, overwritten on every accepted bit
  always_ff @(posedge clk) begin
    if (wr_en) begin
      buf_q[cnt_q[IDX_W-1:0]] <= in_bit;
    end
  end

  assign busy      = (state_q != IDLE);
  assign in_ready  = ready_c;
  assign len_err   = len_err_q;
  assign enc_rst   = enc_rst_q;
  assign enc_b0    = (state_q == ENC) ? buf_q[cnt_q[IDX_W-1:0]] : 1'b0;
  assign out_valid = out_valid_q;
  assign out_c0    = out_c0_q;
  assign out_c1    = out_c1_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

endmodule
